// File: rtl/sad_engine.sv
// sad_engine: sum-of-absolute-differences engine (controller + datapath).
// Consumes LANES pixel pairs per accepted beat, accumulates |a-b| over an
// N_PIX block and publishes the registered SAD alongside a one-cycle done_o pulse.
// Optional feature macro: SAD_EARLY_TERM_EN (threshold early termination,
// adds thr_i / early_o).
module sad_engine #(
  parameter int PIX_W = 8,
  parameter int N_PIX = 256,
  parameter int LANES = 4,
  localparam int SAD_W = PIX_W + $clog2(N_PIX)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [LANES*PIX_W-1:0] a_i,
  input  logic [LANES*PIX_W-1:0] b_i,
  input  logic                   valid_i,
`ifdef SAD_EARLY_TERM_EN
  input  logic [SAD_W-1:0]       thr_i,
  output logic                   early_o,
`endif
  output logic                   ready_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [SAD_W-1:0]       sad_o
);

  localparam int CNT_W = $clog2(N_PIX + 1);

  // Block size must split evenly into beats.
  if (N_PIX % LANES != 0) begin : g_bad_cfg
    $error("sad_engine: N_PIX must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, CLEAR, ACC, DONE} state_t;

  state_t             state_q, state_d;
  logic [SAD_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SAD_W-1:0]   sad_q, sad_d;
  logic               early_q, early_d;

  logic [PIX_W:0]     diff [LANES];
  logic [SAD_W-1:0]   beat_sum;
  logic [SAD_W-1:0]   new_sum;
  logic               accept;
  logic               last_beat;
  logic               over_thr;

  // Per-lane absolute difference, one extra bit of headroom.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [PIX_W:0] a_ext, b_ext;
    assign a_ext    = {1'b0, a_i[gi*PIX_W +: PIX_W]};
    assign b_ext    = {1'b0, b_i[gi*PIX_W +: PIX_W]};
    assign diff[gi] = (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);
  end

  // Reduce lane differences to one beat contribution at full result width.
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      beat_sum = beat_sum + SAD_W'(diff[k]);
    end
  end

  assign new_sum   = sum_q + beat_sum;
  assign accept    = valid_i && ready_o;
  assign last_beat = (cnt_q == CNT_W'(N_PIX - LANES));
`ifdef SAD_EARLY_TERM_EN
  assign over_thr  = (new_sum > thr_i);
`else
  assign over_thr  = 1'b0;
`endif

  // Next-state and datapath update; abort takes priority over a beat accept.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    sad_d   = sad_q;
    early_d = early_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = CLEAR;
      end
      CLEAR: begin
        sum_d   = '0;
        cnt_d   = '0;
        state_d = abort_i ? IDLE : ACC;
      end
      ACC: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (accept) begin
          sum_d = new_sum;
          cnt_d = cnt_q + CNT_W'(LANES);
          // Result is captured on entry to DONE so sad_o is valid with done_o.
          if (last_beat || over_thr) begin
            state_d = DONE;
            sad_d   = new_sum;
            early_d = over_thr;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      sad_q   <= '0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      sad_q   <= sad_d;
      early_q <= early_d;
    end
  end

  assign ready_o = (state_q == ACC);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign sad_o   = sad_q;
`ifdef SAD_EARLY_TERM_EN
  assign early_o = early_q;
`else
  // Early-termination state is unused when the feature is compiled out.
  logic unused_early;
  assign unused_early = early_q;
`endif

endmodule
